// File: rtl/arbiter_pkg.sv
// Shared layout helpers for the writer arbitration path: index/pointer widths
// and the stored entry format {src, data}.
package arbiter_pkg;

  localparam int unsigned WIDTH_DEF       = 8;
  localparam int unsigned DEPTH_DEF       = 16;
  localparam int unsigned NUM_WRITERS_DEF = 2;

  function automatic int unsigned src_width(input int unsigned num_writers);
    return (num_writers > 1) ? $clog2(num_writers) : 1;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned SRC_W_DEF = src_width(NUM_WRITERS_DEF);

  typedef struct packed {
    logic [SRC_W_DEF-1:0] src;
    logic [WIDTH_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/arbitrated_write_fifo_ram.sv
// Simple dual-port register array: one write port, one registered read port.
module fifo_ram #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned ENTRIES = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [ENTRIES];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/arbitrated_write_fifo.sv
// Shared sink FIFO behind the writer arbiter: tags each word with its writer
// index, flags overflow and malformed grants without touching stored data.
module arbitrated_write_fifo
  import arbiter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned NUM_WRITERS = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_we,
  input  logic [NUM_WRITERS-1:0]         i_busy,
  input  logic [NUM_WRITERS*WIDTH-1:0]   i_wdata,
  input  logic                           i_re,
  output logic [WIDTH-1:0]               o_rdata,
  output logic [$clog2(NUM_WRITERS)-1:0] o_rsrc,
  output logic                           o_rvalid,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic                           o_overflow,
  output logic                           o_grant_err
);

  localparam int unsigned SRC_W   = src_width(NUM_WRITERS);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned PW      = ptr_width(DEPTH);
  localparam int unsigned ENTRY_W = SRC_W + WIDTH;

  logic [NUM_WRITERS-1:0] grant;
  logic                   one_hot;
  logic [SRC_W-1:0]       src_idx;
  logic [WIDTH-1:0]       src_data;
  logic [PW-1:0]          wptr;
  logic [PW-1:0]          rptr;
  logic                   full;
  logic                   empty;
  logic                   legal;
  logic                   do_read;
  logic                   do_write;
  logic [ENTRY_W-1:0]     rd_entry;

  assign grant   = ~i_busy;
  assign one_hot = (grant != '0) && ((grant & (grant - NUM_WRITERS'(1))) == '0);

  // OR-reduce index and data over the granted lanes; only valid when one_hot.
  always_comb begin
    src_idx  = '0;
    src_data = '0;
    for (int k = 0; k < int'(NUM_WRITERS); k++) begin
      if (grant[k]) begin
        src_idx  = src_idx | SRC_W'(k);
        src_data = src_data | i_wdata[k*WIDTH +: WIDTH];
      end
    end
  end

  assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign empty    = (wptr == rptr);
  assign legal    = i_we && one_hot;
  assign do_read  = i_re && !empty;
  assign do_write = legal && (!full || do_read);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      o_rvalid    <= 1'b0;
      o_overflow  <= 1'b0;
      o_grant_err <= 1'b0;
    end else begin
      if (do_write) wptr <= wptr + PW'(1);
      if (do_read)  rptr <= rptr + PW'(1);
      o_rvalid <= do_read;
      if (legal && full && !do_read) o_overflow  <= 1'b1;
      if (i_we && !one_hot)          o_grant_err <= 1'b1;
    end
  end

  fifo_ram #(
    .DATA_W (ENTRY_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .we    (do_write),
    .waddr (wptr[AW-1:0]),
    .wdata ({src_idx, src_data}),
    .re    (do_read),
    .raddr (rptr[AW-1:0]),
    .rdata (rd_entry)
  );

  assign o_rdata = rd_entry[WIDTH-1:0];
  assign o_rsrc  = rd_entry[ENTRY_W-1 -: SRC_W];
  assign o_full  = full;
  assign o_empty = empty;
  assign o_count = wptr - rptr;

endmodule

// File: tb/tb_arbitrated_write_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_arbitrated_write_fifo;
  import arbiter_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [NW-1:0] busy;
  logic [NW*WIDTH-1:0] wdata;
  logic          re;
  logic [WIDTH-1:0] rdata;
  logic [0:0]    rsrc;
  logic          rvalid, full, empty, overflow, grant_err;
  logic [4:0]    count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  entry_t q[$];
  entry_t m_head;
  bit     m_rvalid, m_ovf, m_gerr;

  always #5 clk = ~clk;

  arbitrated_write_fifo #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .NUM_WRITERS (NW)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_we        (we),
    .i_busy      (busy),
    .i_wdata     (wdata),
    .i_re        (re),
    .o_rdata     (rdata),
    .o_rsrc      (rsrc),
    .o_rvalid    (rvalid),
    .o_full      (full),
    .o_empty     (empty),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_grant_err (grant_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Continuous comparison against the queue model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count", 32'(count), 32'(q.size()));
      check("model_full", 32'(full), 32'(q.size() == DEPTH));
      check("model_empty", 32'(empty), 32'(q.size() == 0));
      check("model_rvalid", 32'(rvalid), 32'(m_rvalid));
      if (m_rvalid) begin
        check("model_rdata", 32'(rdata), 32'(m_head.data));
        check("model_rsrc", 32'(rsrc), 32'(m_head.src));
      end
      check("model_overflow", 32'(overflow), 32'(m_ovf));
      check("model_grant_err", 32'(grant_err), 32'(m_gerr));
    end
  end

  task automatic model_clear();
    q.delete();
    m_head   = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_gerr   = 1'b0;
  endtask

  // Apply one cycle of stimulus and advance the model by the same edge.
  task automatic cyc(input bit we_i, input logic [1:0] busy_i,
                     input logic [7:0] d0, input logic [7:0] d1, input bit re_i);
    int zeros;
    int k;
    int size_before;
    bit pop;
    entry_t e;
    we = we_i; busy = busy_i; wdata = {d1, d0}; re = re_i;
    @(posedge clk);
    size_before = q.size();
    pop = re_i && (size_before > 0);
    m_rvalid = pop;
    if (pop) m_head = q.pop_front();
    zeros = 0;
    k = 0;
    for (int i = 0; i < int'(NW); i++) if (!busy_i[i]) begin zeros++; k = i; end
    if (we_i) begin
      if (zeros != 1) m_gerr = 1'b1;
      else if (size_before < int'(DEPTH) || pop) begin
        e.src  = 1'(k);
        e.data = (k == 0) ? d0 : d1;
        q.push_back(e);
      end else m_ovf = 1'b1;
    end
    #1;
    we = 1'b0; re = 1'b0; busy = 2'b11;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    #4 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; busy = 2'b11; wdata = '0;
    model_clear();
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_rsrc", 32'(rsrc), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_grant_err", 32'(grant_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Basic write/read
    cyc(1, 2'b10, 8'hA5, 8'h00, 0);
    @(negedge clk);
    check("basic_count1", 32'(count), 32'd1);
    cyc(0, 2'b11, 8'h00, 8'h00, 1);
    @(negedge clk);
    check("basic_rdata", 32'(rdata), 32'hA5);
    check("basic_rsrc", 32'(rsrc), 32'd0);
    check("basic_rvalid", 32'(rvalid), 32'd1);
    check("basic_count0", 32'(count), 32'd0);
    cyc(0, 2'b11, 8'h00, 8'h00, 0);
    @(negedge clk);
    check("basic_rvalid_drop", 32'(rvalid), 32'd0);

    // Fill and overflow
    for (int i = 0; i <= 16; i++) begin
      cyc(1, 2'b01, 8'hEE, 8'(i), 0);
      @(negedge clk);
      if (i == 15) begin
        check("fill_full", 32'(full), 32'd1);
        check("fill_no_ovf", 32'(overflow), 32'd0);
      end
    end
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 2'b11, 8'h00, 8'h00, 1);
      @(negedge clk);
      check("drain_data", 32'(rdata), 32'(i));
      check("drain_src", 32'(rsrc), 32'd1);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Full with simultaneous read/write
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 2'b01, 8'h00, 8'(8'h20 + i), 0);
    cyc(1, 2'b01, 8'h00, 8'h77, 1);
    @(negedge clk);
    check("simul_count", 32'(count), 32'd16);
    check("simul_no_ovf", 32'(overflow), 32'd0);
    check("simul_pop", 32'(rdata), 32'h20);
    for (int i = 0; i < 16; i++) cyc(0, 2'b11, 8'h00, 8'h00, 1);
    @(negedge clk);
    check("simul_last", 32'(rdata), 32'h77);
    check("simul_empty", 32'(empty), 32'd1);

    // Grant errors
    do_reset();
    cyc(1, 2'b11, 8'h11, 8'h22, 0);
    cyc(1, 2'b00, 8'h33, 8'h44, 0);
    @(negedge clk);
    check("gerr_empty", 32'(empty), 32'd1);
    check("gerr_set", 32'(grant_err), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 2'b11, 8'h00, 8'h00, 0);
    @(negedge clk);
    check("gerr_sticky", 32'(grant_err), 32'd1);

    // Empty read, then interleaved traffic across pointer wrap
    do_reset();
    cyc(0, 2'b11, 8'h00, 8'h00, 1);
    @(negedge clk);
    check("empty_read_rvalid", 32'(rvalid), 32'd0);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = 8'(i * 7 + 3);
      cyc(1, (i % 2) ? 2'b01 : 2'b10, d, d, 0);
      @(negedge clk);
      if (count > 5'd1) check("wrap_count_le1", 32'(count), 32'd1);
      cyc(0, 2'b11, 8'h00, 8'h00, 1);
      @(negedge clk);
      check("wrap_data", 32'(rdata), 32'(d));
      check("wrap_src", 32'(rsrc), 32'(i % 2));
    end

    // Asynchronous reset mid-burst
    for (int i = 0; i < 6; i++) cyc(1, 2'b10, 8'(8'h90 + i), 8'h00, 0);
    cyc(0, 2'b11, 8'h00, 8'h00, 1);
    @(negedge clk);
    check("pre_reset_count", 32'(count), 32'd5);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_rvalid", 32'(rvalid), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    cyc(1, 2'b10, 8'h5C, 8'h00, 0);
    cyc(0, 2'b11, 8'h00, 8'h00, 1);
    @(negedge clk);
    check("post_reset_data", 32'(rdata), 32'h5C);
    check("post_reset_empty", 32'(empty), 32'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/arbitrated_write_fifo.md
# arbitrated_write_fifo

Shared sink FIFO at the far end of the writer arbitration path. It accepts one write per cycle from whichever writer currently holds the grant, where the grant is an active-low one-hot busy vector. It stores each word with the index of the writer that produced it and presents entries in order to a single downstream reader. Overflow and grant-protocol violations raise sticky flags instead of corrupting the stored data.

## Interface
- `WIDTH`, 8: data bits per writer.
- `DEPTH`, 16: number of entries; must be a power of two, at least 2.
- `NUM_WRITERS`, 2: number of writers sharing the arbiter; at least 2.
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_we`  in  1  write strobe from the arbiter.
- `i_busy`  in  NUM_WRITERS  arbiter busy vector; a 0 bit marks the granted writer.
- `i_wdata`  in  NUM_WRITERS*WIDTH  concatenated writer data; writer k occupies bits [k*WIDTH +: WIDTH].
- `i_re`  in  1  read request from the consumer.
- `o_rdata`  out  WIDTH  head data, valid while `o_rvalid` is high.
- `o_rsrc`  out  $clog2(NUM_WRITERS)  index of the writer that produced `o_rdata`.
- `o_rvalid`  out  1  read data valid.
- `o_full`  out  1  count equals DEPTH.
- `o_empty`  out  1  count equals 0.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.
- `o_overflow`  out  1  sticky: a legal write was dropped because the FIFO was full.
- `o_grant_err`  out  1  sticky: `i_we` was high while `i_busy` had zero or more than one bit clear.

## Operation
- **Legal write:** `i_we` high and `i_busy` has exactly one bit clear, at index k. The entry written is `{k, i_wdata[k]}`.
- **Illegal grant:** `i_we` high with no zero bits or multiple zero bits in `i_busy`. The write is dropped, `o_grant_err` sets, and pointers do not change.
- **Read:** `i_re` high while not empty pops the head. `i_re` while empty is ignored; it produces no `o_rvalid` and no error.
- **Full with simultaneous read:** the write is accepted and count stays at DEPTH.
- **Full without a read:** the write is dropped and `o_overflow` sets.
- **Empty with simultaneous write:** there is no bypass. The read is ignored and the write lands normally.
- **Pointers:** read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
- **Derived flags:** full when the addresses match and the MSBs differ; empty when the pointers are equal. `o_count` = wptr - rptr, modulo 2^(AW+1).
- **Reset values:** pointers 0, `o_count` 0, `o_empty` 1, `o_full` 0, `o_rvalid` 0, `o_rdata` 0, `o_rsrc` 0, both sticky flags 0. Memory contents are not reset.
- **Sticky flags:** clear only on reset.
- **Reset mid-operation:** all contents are discarded. Outputs return to reset values immediately, without waiting for a clock edge.

## Timing
- **Write:** data is sampled on the rising edge where `i_we` is high. `o_count`, `o_full` and `o_empty` update on that same edge.
- **Read:**
  - `i_re` is sampled at edge N.
  - `o_rdata`, `o_rsrc` and `o_rvalid` are registered and valid after edge N, for one cycle.
  - `o_rvalid` drops at edge N+1 unless another pop occurs.
- **Back-to-back:** one write and one read per cycle are sustained indefinitely.
- **Write-to-read:** the earliest pop is the cycle after the write edge, which gives 2-cycle write-to-`o_rvalid` latency.
- **Flag timing:** `o_overflow` and `o_grant_err` assert on the edge of the offending write.

## Structure
- **Shared package** (`arbiter_pkg`) holds:
  - the width helpers: writer index width, pointer width;
  - the entry typedef `{src, data}`, so arbiter, writers and FIFO agree on the layout.
- **Sub-module** `fifo_ram`: simple dual-port register array, one write port, one registered read port, width `$clog2(NUM_WRITERS)+WIDTH`.
- **Top level** contains:
  - grant decode, one-hot check and priority-free index encode;
  - pointer and flag logic;
  - sticky error registers.

## Test plan
- **Basic write/read:** reset, then write 0xA5 with `i_busy`=2'b10, then pulse `i_re` -> one cycle later `o_rdata`=0xA5, `o_rsrc`=0, `o_rvalid`=1; count goes 1 then 0.
- **Fill and overflow:** with DEPTH=16, do 17 consecutive legal writes from writer 1, data 0..16 -> `o_full`=1 after the 16th; the 17th is dropped and `o_overflow`=1. Draining returns 0..15 with `o_rsrc`=1 throughout.
- **Full with simultaneous read/write:** at full, apply `i_we` and `i_re` in the same cycle -> count stays 16, `o_overflow` stays 0, and the new word appears 16 pops later.
- **Grant errors:** `i_we` with `i_busy`=2'b11, then with 2'b00 -> nothing stored, `o_empty` stays 1, `o_grant_err`=1 and stays high until reset.
- **Empty read and pointer wrap:** `i_re` while empty -> `o_rvalid` stays 0. Then 40 interleaved write/read pairs -> data order is preserved across pointer wrap and count never exceeds 1.
- **Asynchronous reset mid-burst:** assert `i_reset_n` low between clock edges with 5 entries stored -> `o_count`=0, `o_empty`=1, `o_rvalid`=0 immediately. After release, the first read returns only newly written data.
